// File: rtl/rom_readback.sv
// -----------------------------------------------------------------------------
// rom_readback
// Reads a block of ROM words back to the host so a loaded program can be
// verified. While active the block owns the ROM address (rom_read tells the
// top-level mux to select rom_addr over the CPU PC). Each word is presented
// as {addr_out, data_out} on a valid/ready handshake.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   start             one-cycle request, only honoured in IDLE
//   start_addr        first ROM address of the block
//   word_count        number of words, 0..2^ADDR_W
//   rom_addr/rom_read ROM address and ownership flag (rom_read == busy)
//   rom_data          ROM read data, RD_LAT cycles after rom_addr
//   data_out/addr_out word and its address presented to the host
//   out_valid/out_ready host handshake
//   busy              transfer in progress (ISSUE/WAIT/PRESENT)
//   done              one-cycle pulse at the end of a transfer
//   checksum          running sum of accepted words (ROM_CHECKSUM_EN only)
//
// Optional feature macro: ROM_CHECKSUM_EN adds the checksum port and adder.
// -----------------------------------------------------------------------------
module rom_readback #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_read,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
`ifdef ROM_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RD_LAT - 1);
  localparam logic [LAT_W-1:0]  LAT_ONE  = LAT_W'(1);
  localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W + 1)'(0);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   cur_addr_r, cur_addr_s;
  logic [ADDR_W:0]     remaining_r, remaining_s;
  logic [LAT_W-1:0]    lat_cnt_r, lat_cnt_s;
  logic [ADDR_W-1:0]   rom_addr_r, rom_addr_s;
  logic [DATA_W-1:0]   data_out_r, data_out_s;
  logic [ADDR_W-1:0]   addr_out_r, addr_out_s;
  logic                out_valid_r, out_valid_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                accept_s;
  logic                last_wait_s;
`ifdef ROM_CHECKSUM_EN
  logic [DATA_W-1:0]   checksum_r, checksum_s;

  // Modulo-2^DATA_W accumulation of one accepted word.
  function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] word);
    csum_add = acc + word;
  endfunction
`endif

  assign accept_s    = (state_r == ST_PRESENT) & out_valid_r & out_ready;
  // WAIT has lasted RD_LAT cycles, so rom_data now reflects rom_addr.
  assign last_wait_s = (state_r == ST_WAIT) & (lat_cnt_r == LAT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (word_count != CNT_ZERO) begin
            state_s = ST_ISSUE;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_s = ST_WAIT;
      ST_WAIT: begin
        if (last_wait_s) begin
          state_s = ST_PRESENT;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_PRESENT: begin
        if (accept_s) begin
          if (remaining_r == CNT_ONE) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_ISSUE;
          end
        end else begin
          state_s = ST_PRESENT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Output/datapath next values; rom_addr is loaded on the way into ISSUE so
  // the ROM sees the address during the ISSUE cycle itself.
  always_comb begin
    cur_addr_s  = cur_addr_r;
    remaining_s = remaining_r;
    lat_cnt_s   = lat_cnt_r;
    rom_addr_s  = rom_addr_r;
    data_out_s  = data_out_r;
    addr_out_s  = addr_out_r;
    out_valid_s = out_valid_r;
`ifdef ROM_CHECKSUM_EN
    checksum_s  = checksum_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start) begin
`ifdef ROM_CHECKSUM_EN
          checksum_s = {DATA_W{1'b0}};
`endif
          if (word_count != CNT_ZERO) begin
            cur_addr_s  = start_addr;
            remaining_s = word_count;
            rom_addr_s  = start_addr;
          end else begin
            remaining_s = CNT_ZERO;
          end
        end else begin
          out_valid_s = 1'b0;
        end
      end
      ST_ISSUE: begin
        lat_cnt_s = {LAT_W{1'b0}};
      end
      ST_WAIT: begin
        if (last_wait_s) begin
          data_out_s  = rom_data;
          addr_out_s  = cur_addr_r;
          out_valid_s = 1'b1;
        end else begin
          lat_cnt_s = lat_cnt_r + LAT_ONE;
        end
      end
      ST_PRESENT: begin
        if (accept_s) begin
          out_valid_s = 1'b0;
          remaining_s = remaining_r - CNT_ONE;
`ifdef ROM_CHECKSUM_EN
          checksum_s  = csum_add(checksum_r, data_out_r);
`endif
          if (remaining_r != CNT_ONE) begin
            // Address arithmetic is ADDR_W wide, so it wraps naturally.
            cur_addr_s = cur_addr_r + ADDR_ONE;
            rom_addr_s = cur_addr_r + ADDR_ONE;
          end else begin
            cur_addr_s = cur_addr_r;
          end
        end else begin
          out_valid_s = out_valid_r;
        end
      end
      ST_DONE: begin
        out_valid_s = 1'b0;
      end
      default: begin
        out_valid_s = 1'b0;
      end
    endcase

    case (state_s)
      ST_ISSUE, ST_WAIT, ST_PRESENT: busy_s = 1'b1;
      default:                       busy_s = 1'b0;
    endcase
    done_s = (state_s == ST_DONE);
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_addr_r  <= {ADDR_W{1'b0}};
      remaining_r <= CNT_ZERO;
      lat_cnt_r   <= {LAT_W{1'b0}};
      rom_addr_r  <= {ADDR_W{1'b0}};
      data_out_r  <= {DATA_W{1'b0}};
      addr_out_r  <= {ADDR_W{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef ROM_CHECKSUM_EN
      checksum_r  <= {DATA_W{1'b0}};
`endif
    end else begin
      cur_addr_r  <= cur_addr_s;
      remaining_r <= remaining_s;
      lat_cnt_r   <= lat_cnt_s;
      rom_addr_r  <= rom_addr_s;
      data_out_r  <= data_out_s;
      addr_out_r  <= addr_out_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
`ifdef ROM_CHECKSUM_EN
      checksum_r  <= checksum_s;
`endif
    end
  end

  assign rom_addr  = rom_addr_r;
  assign rom_read  = busy_r;
  assign data_out  = data_out_r;
  assign addr_out  = addr_out_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
`ifdef ROM_CHECKSUM_EN
  assign checksum  = checksum_r;
`endif

endmodule

// File: tb/tb_rom_readback.sv
// -----------------------------------------------------------------------------
// tb_rom_readback
// Directed bench for rom_readback. A behavioural ROM answers reads one cycle
// after the address; the expected word stream of each transfer is built from
// start address and count and checked against the host-side handshake on
// every cycle. Hand-computed cycle counts and words pin the model.
// -----------------------------------------------------------------------------
module tb_rom_readback;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 1;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } word_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   word_count;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_read;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] addr_out;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
`ifdef ROM_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  bit busy_seen  = 1'b0;
  bit valid_seen = 1'b0;
  bit hold_prev  = 1'b0;
  word_t             exp_q[$];
  logic [ADDR_W-1:0] obs_addr[$];
  logic [DATA_W-1:0] obs_data[$];

  always #5 clk = ~clk;

  rom_readback #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .word_count(word_count), .rom_addr(rom_addr), .rom_read(rom_read),
    .rom_data(rom_data), .data_out(data_out), .addr_out(addr_out),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
`ifdef ROM_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  function automatic logic [DATA_W-1:0] rom_val(input logic [ADDR_W-1:0] a);
    case (a)
      15'd0:   rom_val = 16'h1111;
      15'd1:   rom_val = 16'h2222;
      15'd2:   rom_val = 16'h3333;
      15'd3:   rom_val = 16'h4444;
      default: rom_val = {1'b1, a} ^ 16'h5AC3;
    endcase
  endfunction

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk) rom_data <= rom_val(rom_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the expected word stream.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rom_read_eq_busy", 64'(rom_read), 64'(busy));
      if (busy) busy_seen = 1'b1;
      if (out_valid) valid_seen = 1'b1;
      if (hold_prev) chk("valid_held_while_stalled", 64'(out_valid), 64'(1'b1));
      if (out_valid) begin
        chk("valid_has_expected_word", 64'(exp_q.size() != 0), 64'(1'b1));
        if (exp_q.size() != 0) begin
          chk("addr_out", 64'(addr_out), 64'(exp_q[0].a));
          chk("data_out", 64'(data_out), 64'(exp_q[0].d));
          if (out_ready) begin
            obs_addr.push_back(addr_out);
            obs_data.push_back(data_out);
            void'(exp_q.pop_front());
          end
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_all_words_seen", 64'(exp_q.size()), 64'(0));
        chk("done_not_busy", 64'(busy), 64'(1'b0));
      end
    end
    hold_prev = out_valid & ~out_ready & ~reset;
  end

  // Runs one transfer; cycles counts edges from the start edge to the edge
  // after the done pulse, first_valid the edges until out_valid first rises.
  task automatic run_xfer(input logic [ADDR_W-1:0] sa, input logic [ADDR_W:0] cnt,
                          input int stall_idx, input int stall_len, input int poke_at,
                          output int cycles, output int first_valid);
    word_t w;
    int dbase;
    int base;
    int stalled;
    for (int k = 0; k < int'(cnt); k++) begin
      w.a = sa + ADDR_W'(k);
      w.d = rom_val(w.a);
      exp_q.push_back(w);
    end
    dbase = done_cnt;
    base = obs_addr.size();
    stalled = 0;
    cycles = -1;
    first_valid = -1;
    busy_seen = 1'b0;
    valid_seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; start_addr = sa; word_count = cnt; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 300 && cycles < 0; i++) begin
      @(posedge clk); #1;
      if (done_cnt > dbase) cycles = i;
      if (out_valid && first_valid < 0) first_valid = i;
      if (out_valid && (obs_addr.size() - base) == stall_idx && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
      end
      if (i == poke_at) begin
        start = 1'b1; start_addr = 15'h1234; word_count = 16'd9;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("xfer_finished_in_budget", 64'(cycles >= 0), 64'(1'b1));
    chk("one_done_pulse", 64'(done_cnt - dbase), 64'(1));
    chk("words_delivered", 64'(obs_addr.size() - base), 64'(cnt));
  endtask

  initial begin
    int cyc;
    int fv;
    int base;
    int dsnap;
    bit hit;
    reset = 1'b1; start = 1'b0; start_addr = '0; word_count = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rom_addr", 64'(rom_addr), 64'(0));
    chk("rst_rom_read", 64'(rom_read), 64'(0));
    chk("rst_data_out", 64'(data_out), 64'(0));
    chk("rst_addr_out", 64'(addr_out), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
`ifdef ROM_CHECKSUM_EN
    chk("rst_checksum", 64'(checksum), 64'(0));
`endif
    reset = 1'b0;

    // Four words from address 0 with the host always ready.
    base = obs_addr.size();
    run_xfer(15'h0000, 16'd4, -1, 0, -1, cyc, fv);
    chk("basic_cycles", 64'(cyc), 64'(13));
    chk("basic_first_valid", 64'(fv), 64'(2));
    chk("basic_addr0", 64'(obs_addr[base]), 64'(15'h0000));
    chk("basic_addr3", 64'(obs_addr[base + 3]), 64'(15'h0003));
    chk("basic_data0", 64'(obs_data[base]), 64'(16'h1111));
    chk("basic_data3", 64'(obs_data[base + 3]), 64'(16'h4444));
`ifdef ROM_CHECKSUM_EN
    chk("basic_checksum", 64'(checksum), 64'(16'hAAAA));
`endif

    // Address wrap at the top of the ROM.
    base = obs_addr.size();
    run_xfer(15'h7FFE, 16'd3, -1, 0, -1, cyc, fv);
    chk("wrap_cycles", 64'(cyc), 64'(10));
    chk("wrap_addr0", 64'(obs_addr[base]), 64'(15'h7FFE));
    chk("wrap_addr1", 64'(obs_addr[base + 1]), 64'(15'h7FFF));
    chk("wrap_addr2", 64'(obs_addr[base + 2]), 64'(15'h0000));

    // Host stalls word index 2 for five cycles.
    base = obs_addr.size();
    run_xfer(15'h0000, 16'd4, 2, 5, -1, cyc, fv);
    chk("stall_cycles", 64'(cyc), 64'(18));
    chk("stall_data2", 64'(obs_data[base + 2]), 64'(16'h3333));
    chk("stall_data3", 64'(obs_data[base + 3]), 64'(16'h4444));

    // Zero-length request.
    run_xfer(15'h0100, 16'd0, -1, 0, -1, cyc, fv);
    chk("zero_cycles", 64'(cyc), 64'(1));
    chk("zero_busy_never", 64'(busy_seen), 64'(1'b0));
    chk("zero_valid_never", 64'(valid_seen), 64'(1'b0));

    // Start pulsed mid-transfer must be ignored.
    base = obs_addr.size();
    run_xfer(15'h0010, 16'd3, -1, 0, 4, cyc, fv);
    chk("poke_cycles", 64'(cyc), 64'(10));
    chk("poke_last_addr", 64'(obs_addr[base + 2]), 64'(15'h0012));
    busy_seen = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("poke_not_queued", 64'(busy_seen), 64'(1'b0));

    // Reset while word index 2 is being presented.
    for (int k = 0; k < 4; k++) begin
      word_t w;
      w.a = ADDR_W'(k);
      w.d = rom_val(w.a);
      exp_q.push_back(w);
    end
    base = obs_addr.size();
    hit = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; start_addr = 15'h0000; word_count = 16'd4; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk); #1;
      if ((obs_addr.size() - base) == 2) out_ready = 1'b0;
      if (out_valid && (obs_addr.size() - base) == 2) hit = 1'b1;
    end
    chk("reach_present_word2", 64'(hit), 64'(1'b1));
    dsnap = done_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    chk("mid_rst_rom_addr", 64'(rom_addr), 64'(0));
    chk("mid_rst_rom_read", 64'(rom_read), 64'(0));
    chk("mid_rst_data_out", 64'(data_out), 64'(0));
    chk("mid_rst_addr_out", 64'(addr_out), 64'(0));
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    reset = 1'b0;
    out_ready = 1'b1;
    busy_seen = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rst_no_done", 64'(done_cnt - dsnap), 64'(0));
    chk("mid_rst_idle", 64'(busy_seen), 64'(1'b0));

    // A fresh transfer after the abort.
    base = obs_addr.size();
    run_xfer(15'h0000, 16'd4, -1, 0, -1, cyc, fv);
    chk("post_rst_cycles", 64'(cyc), 64'(13));
    chk("post_rst_data1", 64'(obs_data[base + 1]), 64'(16'h2222));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
